weight_fifo_sched: RTL and testbench
====================================

WEIGHT_FIFO_SCHED -- requirements
Module: weight_fifo_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the entry count of the attached weight FIFO.
REQ-002 SHALL have parameter ADDR_BW, default 8, meaning the weight-memory tile address width.
REQ-003 SHALL have parameter TILE_BW, default 8, meaning the tile-count width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle job start pulse.
REQ-007 SHALL have port base_addr, input, ADDR_BW bits: first tile address, sampled on accepted start.
REQ-008 SHALL have port num_tiles, input, TILE_BW bits: tiles in the job, sampled on accepted start.
REQ-009 SHALL have port mem_req, output, 1 bit: tile fetch request to weight memory.
REQ-010 SHALL have port mem_addr, output, ADDR_BW bits: fetch address.
REQ-011 SHALL have port mem_ack, input, 1 bit: memory presents tile data on the FIFO data_in this cycle.
REQ-012 SHALL have port fifo_we, output, 1 bit: FIFO write enable.
REQ-013 SHALL have port fifo_re, output, 1 bit: FIFO read enable.
REQ-014 SHALL have port wload_req, input, 1 bit: array level request for the next weight tile.
REQ-015 SHALL have port wload_valid, output, 1 bit: FIFO data_out holds the new tile this cycle.
REQ-016 SHALL have port occupancy, output, $clog2(FIFO_DEPTH)+1 bits: tracked FIFO entries.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle job completion pulse.

Function
REQ-019 SHALL implement the states IDLE, RUN and DONE.
REQ-020 SHALL, in IDLE on start, latch base_addr and num_tiles, clear the fetched and consumed counters, and enter RUN; if num_tiles==0 it SHALL enter DONE instead.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL, in RUN, assert mem_req when fetched<num_tiles and occupancy<FIFO_DEPTH.
REQ-023 SHALL, once mem_req is asserted, hold mem_req and mem_addr stable until mem_ack.
REQ-024 SHALL treat mem_ack as meaningful only while mem_req is high.
REQ-025 SHALL, on mem_req&&mem_ack, drive fifo_we=1 combinationally that cycle, increment mem_addr and fetched next cycle, and increment occupancy.
REQ-026 SHALL drive mem_addr = base_addr + fetched, wrapping modulo 2^ADDR_BW without error.
REQ-027 SHALL, in RUN, issue a one-cycle fifo_re when wload_req=1, occupancy>0 and no write occurs that cycle, then decrement occupancy and increment consumed.
REQ-028 SHALL assert wload_valid exactly 1 cycle after each fifo_re (FIFO read latency is 1).
REQ-029 SHALL never assert fifo_re in the cycle that wload_valid is high, so at most one read is outstanding.
REQ-030 SHALL never assert fifo_we and fifo_re in the same cycle (the FIFO does not support it); on collision the write wins and the read is retried next eligible cycle.
REQ-031 SHALL, when occupancy==0 with wload_req high, issue no fifo_re and leave wload_req pending (underflow never occurs).
REQ-032 SHALL, when occupancy==FIFO_DEPTH, hold mem_req low (overflow never occurs).
REQ-033 SHALL transition from RUN to DONE in the cycle after wload_valid of the tile where consumed reaches num_tiles.
REQ-034 SHALL, in DONE, pulse done for 1 cycle and return to IDLE.
REQ-035 SHALL keep occupancy within 0..FIFO_DEPTH.

Reset
REQ-036 SHALL, while rst=1, force state IDLE and clear every counter and register.
REQ-037 SHALL hold mem_req, fifo_we, fifo_re, wload_valid, busy, done, mem_addr and occupancy at 0 during reset.
REQ-038 SHALL, on reset mid-job, abandon the job; the FIFO is reset concurrently by the same reset.
REQ-039 SHALL need a new start after reset releases.

Verification
REQ-040 SHALL cover single tile: base 0x10, num_tiles=1, ack 2 cycles after mem_req, wload_req held -> one fifo_we, one fifo_re, wload_valid next cycle, done once, busy low after.
REQ-041 SHALL cover full stall: num_tiles=6, wload_req=0 -> exactly 4 writes (addr 0..3), occupancy=4, mem_req low; then raise wload_req -> remaining 2 fetched, 6 reads, done.
REQ-042 SHALL cover collision: mem_ack and wload_req in the same cycle -> fifo_we only; fifo_re next cycle; occupancy correct throughout.
REQ-043 SHALL cover empty and zero jobs: wload_req high with FIFO empty -> no fifo_re until first ack; num_tiles=0 -> done 1 cycle after start, no mem_req.
REQ-044 SHALL cover wrap and reset: ADDR_BW=8, base 0xFE, 4 tiles -> addrs FE, FF, 00, 01; rst mid-job -> all outputs 0 next cycle and start accepted afterwards.
REQ-045 SHALL cover ignored start: start pulsed during RUN -> ignored.

Source files
------------

// File: rtl/weight_fifo_sched.sv
// Weight-tile fetch scheduler: fills an external weight FIFO from memory
// and hands tiles to the array, tracking FIFO occupancy without a full/empty flag.
module weight_fifo_sched #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_BW    = 8,
   parameter int TILE_BW    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ADDR_BW-1:0]            base_addr,
   input  logic [TILE_BW-1:0]            num_tiles,
   output logic                          mem_req,
   output logic [ADDR_BW-1:0]            mem_addr,
   input  logic                          mem_ack,
   output logic                          fifo_we,
   output logic                          fifo_re,
   input  logic                          wload_req,
   output logic                          wload_valid,
   output logic [$clog2(FIFO_DEPTH):0]   occupancy,
   output logic                          busy,
   output logic                          done
);

   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_BW-1:0] base_q, base_d;
   logic [TILE_BW-1:0] ntiles_q, ntiles_d;
   logic [TILE_BW-1:0] fetched_q, fetched_d;
   logic [TILE_BW-1:0] consumed_q, consumed_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic               rvalid_q, rvalid_d;

   logic req, we, re;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      ntiles_d   = ntiles_q;
      fetched_d  = fetched_q;
      consumed_d = consumed_q;
      occ_d      = occ_q;

      // req only drops on ack, so address and request stay stable
      req = (state_q == S_RUN) && (fetched_q < ntiles_q)
            && (occ_q < DEPTH_C);
      we  = req && mem_ack;
      re  = (state_q == S_RUN) && wload_req && (occ_q != '0)
            && !we && !rvalid_q;
      rvalid_d = re;

      if (we) fetched_d = fetched_q + 1'b1;
      if (re) consumed_d = consumed_q + 1'b1;
      if (we && !re) occ_d = occ_q + 1'b1;
      else if (re && !we) occ_d = occ_q - 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d     = base_addr;
               ntiles_d   = num_tiles;
               fetched_d  = '0;
               consumed_d = '0;
               state_d    = (num_tiles == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (rvalid_q && consumed_q == ntiles_q) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         ntiles_q   <= '0;
         fetched_q  <= '0;
         consumed_q <= '0;
         occ_q      <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         ntiles_q   <= ntiles_d;
         fetched_q  <= fetched_d;
         consumed_q <= consumed_d;
         occ_q      <= occ_d;
         rvalid_q   <= rvalid_d;
      end
   end

   // Outputs forced low while reset is held, even before the first edge
   always_comb begin
      mem_req     = 1'b0;
      mem_addr    = '0;
      fifo_we     = 1'b0;
      fifo_re     = 1'b0;
      wload_valid = 1'b0;
      occupancy   = '0;
      busy        = 1'b0;
      done        = 1'b0;
      if (!rst) begin
         mem_req     = req;
         mem_addr    = base_q + ADDR_BW'(fetched_q);
         fifo_we     = we;
         fifo_re     = re;
         wload_valid = rvalid_q;
         occupancy   = occ_q;
         busy        = (state_q != S_IDLE);
         done        = (state_q == S_DONE);
      end
   end

endmodule

// File: tb/tb_weight_fifo_sched.sv
// Directed bench for weight_fifo_sched with an auto-acking memory model
// and a cycle monitor checking handshake and occupancy invariants.
module tb_weight_fifo_sched;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] base_addr;
   logic [7:0] num_tiles;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack;
   logic       fifo_we;
   logic       fifo_re;
   logic       wload_req;
   logic       wload_valid;
   logic [2:0] occupancy;
   logic       busy;
   logic       done;

   logic ack_auto, ack_man, auto_en;
   int   ack_dly, age;

   int n_chk, n_err;
   int n_we, n_re, n_val, n_done, n_mreq, early_re, viol;
   int occ_m;
   logic [7:0] addr_q[$];
   logic       prev_req, prev_ack, prev_re;
   logic [7:0] prev_addr;

   assign mem_ack = ack_auto | ack_man;

   weight_fifo_sched dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .num_tiles  (num_tiles),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .fifo_we    (fifo_we),
      .fifo_re    (fifo_re),
      .wload_req  (wload_req),
      .wload_valid(wload_valid),
      .occupancy  (occupancy),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // memory model: ack ack_dly cycles after mem_req rises
   always @(posedge clk) begin
      #1;
      if (auto_en && mem_req) begin
         if (age >= ack_dly) begin
            ack_auto = 1'b1;
            age = 0;
         end else begin
            ack_auto = 1'b0;
            age++;
         end
      end else begin
         ack_auto = 1'b0;
         age = 0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         occ_m   = 0;
         prev_re = 1'b0;
         prev_req = 1'b0;
      end else begin
         if (occupancy !== 3'(occ_m)) viol++;
         if (fifo_we && fifo_re) viol++;
         if (fifo_re && wload_valid) viol++;
         if (occupancy > 3'd4) viol++;
         if (wload_valid !== prev_re) viol++;
         if (prev_req && !prev_ack &&
             (mem_req !== 1'b1 || mem_addr !== prev_addr)) viol++;
         if (fifo_re && n_we == 0) early_re++;
         if (fifo_we) begin
            n_we++;
            addr_q.push_back(mem_addr);
         end
         if (fifo_re) n_re++;
         if (wload_valid) n_val++;
         if (done) n_done++;
         if (mem_req) n_mreq++;
         occ_m = occ_m + int'(fifo_we) - int'(fifo_re);
         prev_re  = fifo_re;
         prev_req = mem_req;
         prev_ack = mem_ack;
         prev_addr = mem_addr;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      n_we = 0; n_re = 0; n_val = 0; n_done = 0;
      n_mreq = 0; early_re = 0;
      addr_q.delete();
   endtask

   task automatic start_job(input logic [7:0] b, input logic [7:0] n);
      nxt();
      start = 1'b1;
      base_addr = b;
      num_tiles = n;
      nxt();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int k;
      k = 0;
      while (n_done == 0 && k < max) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(n_done != 0), 32'd1);
   endtask

   task automatic chk_addrs(input string tag, input logic [7:0] b,
                            input int n);
      logic [7:0] a;
      for (int i = 0; i < n; i++) begin
         a = (i < addr_q.size()) ? addr_q[i] : 8'hxx;
         chk(tag, 32'(a), 32'(8'(b + 8'(i))));
      end
   endtask

   initial begin
      n_chk = 0; n_err = 0; viol = 0; occ_m = 0;
      prev_re = 0; prev_req = 0; prev_ack = 0; prev_addr = 0;
      rst = 1'b1; start = 1'b0; base_addr = 0; num_tiles = 0;
      wload_req = 1'b0; ack_man = 1'b0; ack_auto = 1'b0;
      auto_en = 1'b1; ack_dly = 0; age = 0;
      clr_stats();

      // reset state
      nxt(); nxt(); nxt();
      @(negedge clk);
      chk("rst_ctl", {26'd0, mem_req, fifo_we, fifo_re, wload_valid,
          busy, done}, 32'd0);
      chk("rst_addr_occ", {21'd0, mem_addr, occupancy}, 32'd0);
      nxt();
      rst = 1'b0;

      // single tile
      clr_stats();
      ack_dly = 2; wload_req = 1'b1;
      start_job(8'h10, 8'd1);
      wait_done("one_to", 50);
      nxt(); nxt();
      @(negedge clk);
      chk("one_we", n_we, 1);
      chk_addrs("one_addr", 8'h10, 1);
      chk("one_re", n_re, 1);
      chk("one_val", n_val, 1);
      chk("one_done", n_done, 1);
      chk("one_busy", 32'(busy), 0);

      // full stall then drain
      clr_stats();
      ack_dly = 0; wload_req = 1'b0;
      start_job(8'h00, 8'd6);
      repeat (15) nxt();
      @(negedge clk);
      chk("stall_we", n_we, 4);
      chk("stall_occ", 32'(occupancy), 4);
      chk("stall_req", 32'(mem_req), 0);
      chk("stall_re", n_re, 0);
      wload_req = 1'b1;
      wait_done("stall_to", 100);
      chk("stall_we_tot", n_we, 6);
      chk_addrs("stall_addr", 8'h00, 6);
      chk("stall_re_tot", n_re, 6);
      chk("stall_val", n_val, 6);
      wload_req = 1'b0;
      nxt(); nxt();

      // write/read collision
      clr_stats();
      auto_en = 1'b0;
      start_job(8'h20, 8'd2);
      ack_man = 1'b1;
      @(negedge clk);
      chk("col_we1", 32'(fifo_we), 1);
      chk("col_addr1", 32'(mem_addr), 32'h20);
      nxt();
      ack_man = 1'b1; wload_req = 1'b1;
      @(negedge clk);
      chk("col_we2", 32'(fifo_we), 1);
      chk("col_re2", 32'(fifo_re), 0);
      chk("col_occ2", 32'(occupancy), 1);
      chk("col_addr2", 32'(mem_addr), 32'h21);
      nxt();
      ack_man = 1'b0;
      @(negedge clk);
      chk("col_re3", 32'(fifo_re), 1);
      chk("col_occ3", 32'(occupancy), 2);
      chk("col_req3", 32'(mem_req), 0);
      nxt();
      @(negedge clk);
      chk("col_val4", 32'(wload_valid), 1);
      chk("col_re4", 32'(fifo_re), 0);
      chk("col_occ4", 32'(occupancy), 1);
      nxt();
      @(negedge clk);
      chk("col_re5", 32'(fifo_re), 1);
      wait_done("col_to", 20);
      chk("col_re_tot", n_re, 2);
      wload_req = 1'b0; auto_en = 1'b1;
      nxt(); nxt();

      // empty FIFO with reader waiting
      clr_stats();
      ack_dly = 3; wload_req = 1'b1;
      start_job(8'h30, 8'd1);
      wait_done("empty_to", 50);
      chk("empty_early_re", early_re, 0);
      chk("empty_re", n_re, 1);
      chk("empty_we", n_we, 1);
      wload_req = 1'b0;
      nxt(); nxt();

      // zero-tile job
      clr_stats();
      start_job(8'h00, 8'd0);
      @(negedge clk);
      chk("zero_done", 32'(done), 1);
      nxt();
      @(negedge clk);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_mreq", n_mreq, 0);
      chk("zero_done_cnt", n_done, 1);

      // address wrap
      clr_stats();
      ack_dly = 1; wload_req = 1'b1;
      start_job(8'hFE, 8'd4);
      wait_done("wrap_to", 100);
      chk("wrap_we", n_we, 4);
      chk_addrs("wrap_addr", 8'hFE, 4);
      wload_req = 1'b0;
      nxt(); nxt();

      // reset mid-job
      clr_stats();
      ack_dly = 0;
      start_job(8'h00, 8'd6);
      nxt(); nxt(); nxt();
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_ctl", {26'd0, mem_req, fifo_we, fifo_re, wload_valid,
          busy, done}, 32'd0);
      nxt();
      @(negedge clk);
      chk("mrst_addr_occ", {21'd0, mem_addr, occupancy}, 32'd0);
      rst = 1'b0;
      nxt();
      @(negedge clk);
      chk("mrst_idle", {30'd0, busy, mem_req}, 32'd0);
      clr_stats();
      wload_req = 1'b1;
      start_job(8'h40, 8'd2);
      wait_done("mrst_to", 50);
      chk("mrst_we", n_we, 2);
      chk_addrs("mrst_addr", 8'h40, 2);
      chk("mrst_re", n_re, 2);
      wload_req = 1'b0;
      nxt(); nxt();

      // start ignored while running
      clr_stats();
      start_job(8'h50, 8'd3);
      repeat (6) nxt();
      start = 1'b1; base_addr = 8'h90; num_tiles = 8'd1;
      nxt();
      start = 1'b0;
      nxt(); nxt();
      @(negedge clk);
      chk("ign_we", n_we, 3);
      chk("ign_busy", 32'(busy), 1);
      wload_req = 1'b1;
      wait_done("ign_to", 50);
      chk("ign_re", n_re, 3);
      chk_addrs("ign_addr", 8'h50, 3);
      chk("ign_done", n_done, 1);
      wload_req = 1'b0;
      nxt(); nxt();

      chk("invariants", viol, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
